// File: rtl/eth_frame_log_mux.sv
// Round-robin, frame-atomic merge of N log streams onto one AXIS output.
// Adds per-channel drain, max-length truncation and drop/trunc counters.
module eth_frame_log_mux #(
  parameter int C_NUM_CHANNELS   = 4,
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_MAX_BEATS      = 256
) (
  input  logic                                         s_axi_clk,
  input  logic                                         s_axi_resetn,
  input  logic                                         srst,
  input  logic [C_NUM_CHANNELS-1:0]                    chan_en,
  input  logic [C_NUM_CHANNELS*C_AXIS_LOG_WIDTH-1:0]   s_axis_log_tdata,
  input  logic [C_NUM_CHANNELS-1:0]                    s_axis_log_tlast,
  input  logic [C_NUM_CHANNELS-1:0]                    s_axis_log_tvalid,
  output logic [C_NUM_CHANNELS-1:0]                    s_axis_log_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0]                  m_axis_log_tdata,
  output logic [((C_NUM_CHANNELS > 1) ?
                 $clog2(C_NUM_CHANNELS) : 1)-1:0]      m_axis_log_tdest,
  output logic                                         m_axis_log_tlast,
  output logic                                         m_axis_log_tvalid,
  input  logic                                         m_axis_log_tready,
  output logic [32*C_NUM_CHANNELS-1:0]                 drop_count,
  output logic [31:0]                                  trunc_count
);

  localparam int N  = C_NUM_CHANNELS;
  localparam int W  = C_AXIS_LOG_WIDTH;
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(C_MAX_BEATS + 1);
  localparam logic [DW-1:0] LAST_CH = DW'(N - 1);
  localparam logic [BW-1:0] CNT_TOP = BW'(C_MAX_BEATS - 1);
  localparam logic [31:0]   SAT     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          grant_q, grant_d;
  logic [DW-1:0]          last_grant_q, last_grant_d;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [W-1:0]           m_data_q, m_data_d;
  logic [DW-1:0]          m_dest_q, m_dest_d;
  logic                   m_last_q, m_last_d;
  logic                   m_valid_q, m_valid_d;
  logic [N-1:0]           drain_hold_q, drain_hold_d;
  logic [N-1:0][31:0]     drop_cnt_q, drop_cnt_d;
  logic [31:0]            trunc_cnt_q, trunc_cnt_d;

  logic                   rst;
  logic                   out_free;
  logic [N-1:0]           eligible;
  logic [N-1:0]           granted_oh;
  logic [N-1:0]           drain;
  logic [N-1:0]           rdy;
  logic                   pick_found;
  logic [DW-1:0]          pick_idx;
  logic [DW-1:0]          cand;
  logic                   g_valid;
  logic                   g_last;
  logic [W-1:0]           g_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == SAT) ? v : v + 32'd1;
  endfunction

  assign rst      = ~s_axi_resetn | srst;
  assign out_free = ~m_valid_q | m_axis_log_tready;
  assign eligible = s_axis_log_tvalid & chan_en & ~drain_hold_q;

  always_comb begin
    granted_oh = '0;
    if (state_q != IDLE) begin
      granted_oh[grant_q] = 1'b1;
    end
  end

  assign drain = ~granted_oh & (~chan_en | drain_hold_q);

  // Scan starts one past the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = DW'((int'(last_grant_q) + k) % N);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == DW'(i)) begin
        g_valid = s_axis_log_tvalid[i];
        g_last  = s_axis_log_tlast[i];
        g_data  = s_axis_log_tdata[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    m_data_d     = m_data_q;
    m_dest_d     = m_dest_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q & ~m_axis_log_tready;
    trunc_cnt_d  = trunc_cnt_q;
    drain_hold_d = drain_hold_q;
    drop_cnt_d   = drop_cnt_q;
    rdy          = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
          state_d      = FORWARD;
        end
      end
      FORWARD: begin
        rdy[grant_q] = out_free;
        if (g_valid && out_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = g_data;
          m_dest_d   = grant_q;
          m_last_d   = g_last;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (g_last) begin
            state_d = IDLE;
          end else if (beat_cnt_q == CNT_TOP) begin
            m_last_d    = 1'b1;
            trunc_cnt_d = sat_inc(trunc_cnt_q);
            state_d     = DISCARD;
          end
        end
      end
      DISCARD: begin
        rdy[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle or disabled channels sink whole frames so fragments never leak.
    for (int i = 0; i < N; i++) begin
      if (drain[i]) begin
        rdy[i] = 1'b1;
        if (s_axis_log_tvalid[i]) begin
          if (s_axis_log_tlast[i]) begin
            drain_hold_d[i] = 1'b0;
            drop_cnt_d[i]   = sat_inc(drop_cnt_q[i]);
          end else begin
            drain_hold_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      beat_cnt_q   <= '0;
      m_data_q     <= '0;
      m_dest_q     <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      drain_hold_q <= '0;
      drop_cnt_q   <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      m_data_q     <= m_data_d;
      m_dest_q     <= m_dest_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      drain_hold_q <= drain_hold_d;
      drop_cnt_q   <= drop_cnt_d;
      trunc_cnt_q  <= trunc_cnt_d;
    end
  end

  assign s_axis_log_tready = rdy & {N{~rst}};
  assign m_axis_log_tdata  = m_data_q;
  assign m_axis_log_tdest  = m_dest_q;
  assign m_axis_log_tlast  = m_last_q;
  assign m_axis_log_tvalid = m_valid_q;
  assign drop_count        = drop_cnt_q;
  assign trunc_count       = trunc_cnt_q;

endmodule

// File: tb/tb_eth_frame_log_mux.sv
// Bench for eth_frame_log_mux: frame-level scoreboard with random traffic.
// Expected output is derived per channel from the frames each channel sends.
module tb_eth_frame_log_mux;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             srst;
  logic [N-1:0]     chan_en;
  logic [N*W-1:0]   s_tdata;
  logic [N-1:0]     s_tlast;
  logic [N-1:0]     s_tvalid;
  logic [N-1:0]     s_tready;
  logic [W-1:0]     m_tdata;
  logic [1:0]       m_tdest;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [32*N-1:0]  drop_count;
  logic [31:0]      trunc_count;

  always #5 clk = ~clk;

  eth_frame_log_mux #(
    .C_NUM_CHANNELS  (N),
    .C_AXIS_LOG_WIDTH(W),
    .C_MAX_BEATS     (MB)
  ) dut (
    .s_axi_clk        (clk),
    .s_axi_resetn     (rstn),
    .srst             (srst),
    .chan_en          (chan_en),
    .s_axis_log_tdata (s_tdata),
    .s_axis_log_tlast (s_tlast),
    .s_axis_log_tvalid(s_tvalid),
    .s_axis_log_tready(s_tready),
    .m_axis_log_tdata (m_tdata),
    .m_axis_log_tdest (m_tdest),
    .m_axis_log_tlast (m_tlast),
    .m_axis_log_tvalid(m_tvalid),
    .m_axis_log_tready(m_tready),
    .drop_count       (drop_count),
    .trunc_count      (trunc_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        en;
    logic        fwd;
    logic [7:0]  idx;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } obeat_t;

  beat_t  tx_q[N][$];
  obeat_t exp_q[N][$];
  int     exp_drop[N];
  int     exp_trunc;
  int     dest_log[$];
  int     n_chk;
  int     n_err;
  int     stall_cycles;
  int     got;
  logic   acc1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_done();
    for (int c = 0; c < N; c++) begin
      if (tx_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int dl(input int i);
    return (i < dest_log.size()) ? dest_log[i] : -1;
  endfunction

  task automatic add_frame(input int ch, input int len, input bit en,
                           input bit en_rest, input logic [63:0] base);
    for (int k = 0; k < len; k++) begin
      beat_t  b;
      obeat_t o;
      b.data = (base != 0) ? base + 64'(k) : {$urandom, $urandom};
      b.last = (k == len - 1);
      b.en   = (k == 0) ? en : en_rest;
      b.fwd  = en;
      b.idx  = 8'(k);
      tx_q[ch].push_back(b);
      if (en && k < MB) begin
        o.data = b.data;
        o.last = (k == len - 1) || (k == MB - 1);
        exp_q[ch].push_back(o);
      end
    end
    if (!en) exp_drop[ch]++;
    else if (len > MB) exp_trunc++;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_trunc"}, trunc_count, 64'(exp_trunc));
    for (int c = 0; c < N; c++) begin
      chk($sformatf("%s_drop%0d", tag, c), drop_count[c*32 +: 32],
          64'(exp_drop[c]));
    end
  endtask

  task automatic run(input int budget, input int gap_pct, input int rdy_mode);
    logic [N-1:0] acc;
    logic         oacc;
    logic [63:0]  od;
    logic [1:0]   odest;
    logic         ol;
    logic         pstall;
    logic [63:0]  pd;
    logic [1:0]   pdest;
    logic         pl;
    bit           in_frame;
    int           cur_dest;
    int           n_out;
    int           stall_left;
    bit           stall_done;
    obeat_t       o;
    pstall = 1'b0; pd = '0; pdest = '0; pl = 1'b0;
    in_frame = 1'b0; cur_dest = 0; n_out = 0;
    stall_left = 0; stall_done = 1'b0; stall_cycles = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (all_done()) break;
      for (int c = 0; c < N; c++) begin
        if (tx_q[c].size() != 0) begin
          chan_en[c] = tx_q[c][0].en;
          if (!s_tvalid[c]) s_tvalid[c] = ($urandom_range(99) >= gap_pct);
          s_tdata[c*W +: W] = tx_q[c][0].data;
          s_tlast[c] = tx_q[c][0].last;
        end else begin
          s_tvalid[c] = 1'b0;
        end
      end
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(99) < 70);
        default: begin
          if (!stall_done && n_out == 2) begin
            stall_left = 5;
            stall_done = 1'b1;
          end
          m_tready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        acc[c] = s_tvalid[c] & s_tready[c];
        if (s_tvalid[c] && tx_q[c].size() != 0) begin
          if (!tx_q[c][0].fwd) chk("drain_rdy", 64'(s_tready[c]), 1);
          else if (m_tvalid && !m_tready && tx_q[c][0].idx < MB)
            chk("stall_rdy", 64'(s_tready[c]), 0);
        end
      end
      if (pstall) begin
        chk("hold_valid", 64'(m_tvalid), 1);
        chk("hold_data", m_tdata, pd);
        chk("hold_dest", 64'(m_tdest), 64'(pdest));
        chk("hold_last", 64'(m_tlast), 64'(pl));
      end
      pstall = m_tvalid & ~m_tready;
      pd = m_tdata; pdest = m_tdest; pl = m_tlast;
      if (pstall) stall_cycles++;
      oacc = m_tvalid & m_tready;
      od = m_tdata; odest = m_tdest; ol = m_tlast;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (acc[c]) begin
          void'(tx_q[c].pop_front());
          s_tvalid[c] = 1'b0;
        end
      end
      if (oacc) begin
        n_out++;
        if (in_frame) chk("dest_const", 64'(odest), 64'(cur_dest));
        chk("beat_avail", 64'(exp_q[odest].size() != 0), 1);
        if (exp_q[odest].size() != 0) begin
          o = exp_q[odest].pop_front();
          chk("data", od, o.data);
          chk("last", 64'(ol), 64'(o.last));
        end
        if (ol) begin
          in_frame = 1'b0;
          dest_log.push_back(int'(odest));
        end else begin
          in_frame = 1'b1;
          cur_dest = int'(odest);
        end
      end
    end
    chk("finished", 64'(all_done()), 1);
    s_tvalid = '0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; exp_trunc = 0;
    foreach (exp_drop[i]) exp_drop[i] = 0;
    rstn = 1'b0; srst = 1'b0; chan_en = '1;
    s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(m_tvalid), 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_dest", 64'(m_tdest), 0);
    chk("rst_last", 64'(m_tlast), 0);
    chk_cnt("rst");
    @(posedge clk);
    #1;

    dest_log.delete();
    add_frame(1, 3, 1, 1, 64'h1111_1111_1111_1100);
    add_frame(3, 3, 1, 1, 64'h3333_3333_3333_3300);
    run(200, 0, 0);
    chk("t1_first", 64'(dl(0)), 1);
    chk("t1_second", 64'(dl(1)), 3);

    dest_log.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) add_frame(c, 1, 1, 1, 0);
    run(200, 0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_rr%0d", i), 64'(dl(i)), 64'(i % N));

    add_frame(2, 11, 1, 1, 0);
    add_frame(2, 3, 1, 1, 0);
    add_frame(2, 8, 1, 1, 0);
    run(300, 0, 0);
    chk_cnt("t3");

    add_frame(0, 2, 0, 0, 0);
    add_frame(0, 2, 0, 0, 0);
    run(200, 0, 0);
    chk_cnt("t4a");
    add_frame(0, 3, 0, 1, 0);
    add_frame(0, 2, 1, 1, 0);
    run(200, 0, 0);
    chk_cnt("t4b");

    add_frame(1, 4, 1, 1, 0);
    run(200, 0, 2);
    chk("t5_stall", 64'(stall_cycles), 5);

    chan_en = '1; m_tready = 1'b1; got = 0;
    s_tdata[W +: W] = 64'hA0; s_tlast[1] = 1'b0; s_tvalid[1] = 1'b1;
    for (int k = 0; k < 50 && got < 2; k++) begin
      @(negedge clk);
      acc1 = s_tready[1];
      @(posedge clk);
      #1;
      if (acc1) begin
        got++;
        s_tdata[W +: W] = 64'hA0 + 64'(got);
      end
    end
    chk("t6_pre", 64'(got), 2);
    srst = 1'b1;
    @(negedge clk);
    chk("t6_srst_rdy", 64'(s_tready[1]), 0);
    @(posedge clk);
    #1;
    srst = 1'b0; s_tvalid[1] = 1'b0;
    exp_trunc = 0;
    foreach (exp_drop[i]) exp_drop[i] = 0;
    chk("t6_valid", 64'(m_tvalid), 0);
    chk("t6_data", m_tdata, 0);
    chk_cnt("t6");
    dest_log.delete();
    add_frame(0, 1, 1, 1, 0);
    add_frame(2, 1, 1, 1, 0);
    run(100, 0, 0);
    chk("t6_first", 64'(dl(0)), 0);
    chk("t6_second", 64'(dl(1)), 2);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N; c++) begin
        for (int f = 0; f < 5; f++) begin
          bit en;
          en = ($urandom_range(99) < 80);
          add_frame(c, int'($urandom_range(11, 1)), en, en, 0);
        end
      end
      run(4000, 30, 1);
      chk_cnt("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
